// File: rtl/proc_pkg.sv
// Shared defaults and the output clamp used by the scaled averaging pipeline.
package proc_pkg;

    localparam int         WIDTH_DEF      = 10;
    localparam int         LOG2_DEPTH_DEF = 2;
    localparam logic [9:0] ADC_OFFSET_DEF = 10'h181;
    localparam logic [9:0] DAC_OFFSET_DEF = 10'h200;

    // Clamp a signed value to the two's-complement range of a width-bit word.
    function automatic int saturate(input int value, input int width);
        int hi;
        int lo;
        hi = (1 << (width - 1)) - 1;
        lo = -(1 << (width - 1));
        if (value > hi) begin
            return hi;
        end
        if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/avg_buffer.sv
// Circular window of the last 2**LOG2_DEPTH samples plus their running sum.
module avg_buffer #(
    parameter int DW         = 11,
    parameter int LOG2_DEPTH = 2
) (
    input  logic                               sysclk,
    input  logic                               rst_n,
    input  logic                               push,
    input  logic signed [DW-1:0]               x_in,
    output logic signed [DW+LOG2_DEPTH-1:0]    sum_next
);

    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int SW    = DW + LOG2_DEPTH;

    logic signed [DW-1:0]    entries [DEPTH];
    logic signed [SW-1:0]    sum_q;
    logic [LOG2_DEPTH-1:0]   wr_idx;

    // The entry about to be overwritten is the oldest one in the window.
    assign sum_next = sum_q + SW'(x_in) - SW'(entries[wr_idx]);

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            wr_idx <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (push) begin
            sum_q           <= sum_next;
            entries[wr_idx] <= x_in;
            wr_idx          <= wr_idx + LOG2_DEPTH'(1);
        end
    end

endmodule

// File: rtl/scaled_averager.sv
// Three-stage offset-remove / moving-average / gain-and-clamp pipeline from ADC codes to DAC codes.
module scaled_averager
    import proc_pkg::*;
#(
    parameter int               WIDTH      = WIDTH_DEF,
    parameter logic [WIDTH-1:0] ADC_OFFSET = ADC_OFFSET_DEF,
    parameter logic [WIDTH-1:0] DAC_OFFSET = DAC_OFFSET_DEF,
    parameter int               LOG2_DEPTH = LOG2_DEPTH_DEF
) (
    input  logic             sysclk,
    input  logic             rst_n,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] data_in,
    input  logic [1:0]       gain_sel,
    input  logic             avg_en,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    output logic             sat_flag
);

    localparam int XW = WIDTH + 1;
    localparam int SW = XW + LOG2_DEPTH;
    localparam int YW = WIDTH + 4;

    logic                 s1_valid;
    logic signed [XW-1:0] s1_x;
    logic [1:0]           s1_gain;
    logic                 s1_avg;

    logic signed [SW-1:0] sum_next;
    logic signed [XW-1:0] avg_value;

    logic                 s2_valid;
    logic signed [XW-1:0] s2_result;
    logic [1:0]           s2_gain;

    logic signed [YW-1:0] y;
    int                   y_int;
    int                   clamped;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_gain  <= '0;
            s1_avg   <= 1'b0;
        end else begin
            s1_valid <= sample_valid;
            if (sample_valid) begin
                s1_x    <= $signed({1'b0, data_in}) - $signed({1'b0, ADC_OFFSET});
                s1_gain <= gain_sel;
                s1_avg  <= avg_en;
            end
        end
    end

    avg_buffer #(
        .DW         (XW),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_avg_buffer (
        .sysclk   (sysclk),
        .rst_n    (rst_n),
        .push     (s1_valid),
        .x_in     (s1_x),
        .sum_next (sum_next)
    );

    // Arithmetic shift gives a floor average; the window mean always fits in XW bits.
    assign avg_value = XW'(sum_next >>> LOG2_DEPTH);

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_gain   <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_result <= s1_avg ? avg_value : s1_x;
                s2_gain   <= s1_gain;
            end
        end
    end

    always_comb begin
        y       = YW'(s2_result) <<< s2_gain;
        y_int   = int'(y);
        clamped = saturate(y_int, WIDTH);
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            data_out  <= DAC_OFFSET;
            sat_flag  <= 1'b0;
        end else begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                data_out <= WIDTH'(clamped) + DAC_OFFSET;
                sat_flag <= (clamped != y_int);
            end
        end
    end

endmodule

// File: tb/tb_scaled_averager.sv
// Randomised and directed bench for scaled_averager against an arithmetic window model.
module tb_scaled_averager;

    localparam int DEPTH = 4;
    localparam int ADC   = 'h181;
    localparam int DAC   = 'h200;

    logic       sysclk = 1'b0;
    logic       rst_n;
    logic       sample_valid;
    logic [9:0] data_in;
    logic [1:0] gain_sel;
    logic       avg_en;
    logic [9:0] data_out;
    logic       out_valid;
    logic       sat_flag;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit v;
        int data;
        bit sat;
    } exp_t;

    exp_t       dl [3];
    int         hist [$];
    bit         exp_valid;
    logic [9:0] exp_data;
    bit         exp_sat;

    scaled_averager dut (
        .sysclk       (sysclk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .data_in      (data_in),
        .gain_sel     (gain_sel),
        .avg_en       (avg_en),
        .data_out     (data_out),
        .out_valid    (out_valid),
        .sat_flag     (sat_flag)
    );

    always #5 sysclk = ~sysclk;

    task automatic model_clear();
        hist.delete();
        for (int i = 0; i < 3; i++) begin
            dl[i].v    = 1'b0;
            dl[i].data = 0;
            dl[i].sat  = 1'b0;
        end
        exp_valid = 1'b0;
        exp_data  = 10'h200;
        exp_sat   = 1'b0;
    endtask

    // Drive one cycle, then predict what the outputs show just after the edge.
    task automatic clock_cycle(input bit v, input int din, input int g, input bit a);
        exp_t e;
        sample_valid = v;
        data_in      = din[9:0];
        gain_sel     = g[1:0];
        avg_en       = a;
        @(posedge sysclk);
        #1;
        e.v    = v;
        e.data = 0;
        e.sat  = 1'b0;
        if (v) begin
            int x, s, r, y, c;
            x = din - ADC;
            hist.push_back(x);
            while (hist.size() > DEPTH) void'(hist.pop_front());
            s = 0;
            foreach (hist[k]) s += hist[k];
            if (a) begin
                r = s / DEPTH;
                if (s < 0 && (s % DEPTH) != 0) r -= 1;
            end else begin
                r = x;
            end
            y = r * (1 << g);
            c = (y > 511) ? 511 : ((y < -512) ? -512 : y);
            e.sat  = (c != y);
            e.data = (c + DAC + 1024) % 1024;
        end
        dl[2] = dl[1];
        dl[1] = dl[0];
        dl[0] = e;
        exp_valid = dl[2].v;
        if (dl[2].v) begin
            exp_data = dl[2].data[9:0];
            exp_sat  = dl[2].sat;
        end
        sample_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sample_valid = 1'b0;
        data_in = '0;
        gain_sel = '0;
        avg_en = 1'b0;
        model_clear();
        repeat (3) @(posedge sysclk);
        #1;
        checks++;
        if (data_out !== 10'h200) begin errors++; $display("[TB] FAIL reset_data: got %h expected 200", data_out); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", out_valid); end
        checks++;
        if (sat_flag !== 1'b0) begin errors++; $display("[TB] FAIL reset_sat: got %b expected 0", sat_flag); end
        @(negedge sysclk);
        rst_n = 1'b1;
        @(posedge sysclk);
        #1;
    endtask

    task automatic test_midscale();
        for (int i = 0; i < 6; i++) begin
            clock_cycle(i == 0, 'h181, 0, 1'b0);
            checks++;
            if (out_valid !== (i == 2)) begin
                errors++;
                $display("[TB] FAIL midscale_latency cycle %0d: got %b expected %b", i, out_valid, (i == 2));
            end
            if (i == 2) begin
                checks++;
                if (data_out !== 10'h200 || sat_flag !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL midscale_data: got %h sat %b expected 200 sat 0", data_out, sat_flag);
                end
            end
        end
    endtask

    // Directed sample list whose output pulses must match the given constants in order.
    task automatic run_directed(input string name, input int din [$], input int gs [$], input bit av [$],
                                input logic [9:0] want [$], input bit want_sat [$]);
        int p = 0;
        for (int i = 0; i < din.size() + 4; i++) begin
            if (i < din.size()) clock_cycle(1'b1, din[i], gs[i], av[i]);
            else clock_cycle(1'b0, 0, 0, 1'b0);
            checks++;
            if (out_valid !== exp_valid || data_out !== exp_data || sat_flag !== exp_sat) begin
                errors++;
                $display("[TB] FAIL %s_model cycle %0d: got v%b %h s%b expected v%b %h s%b",
                         name, i, out_valid, data_out, sat_flag, exp_valid, exp_data, exp_sat);
            end
            if (out_valid === 1'b1) begin
                checks++;
                if (p >= want.size() || data_out !== want[p] || sat_flag !== want_sat[p]) begin
                    errors++;
                    $display("[TB] FAIL %s_pulse%0d: got %h sat %b expected %h sat %b",
                             name, p, data_out, sat_flag, want[p], want_sat[p]);
                end
                p++;
            end
        end
        checks++;
        if (p != want.size()) begin
            errors++;
            $display("[TB] FAIL %s_count: got %0d pulses expected %0d", name, p, want.size());
        end
    endtask

    task automatic test_gain();
        run_directed("gain", '{'h191, 'h191}, '{2, 3}, '{1'b0, 1'b0}, '{10'h240, 10'h280}, '{1'b0, 1'b0});
    endtask

    task automatic test_saturation();
        run_directed("sat", '{'h3FF, 'h000, 'h181}, '{0, 1, 0}, '{1'b0, 1'b0, 1'b0},
                     '{10'h3FF, 10'h000, 10'h200}, '{1'b1, 1'b1, 1'b0});
    endtask

    task automatic test_warmup();
        rst_n = 1'b0;
        model_clear();
        #3;
        rst_n = 1'b1;
        clock_cycle(1'b0, 0, 0, 1'b0);
        run_directed("warmup", '{'h191, 'h191, 'h191, 'h191, 'h181}, '{0, 0, 0, 0, 0},
                     '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1},
                     '{10'h204, 10'h208, 10'h20C, 10'h210, 10'h20C}, '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    endtask

    task automatic test_gaps();
        for (int i = 0; i < 18; i++) begin
            clock_cycle((i % 3) == 0, $urandom_range(0, 1023), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            checks++;
            if (out_valid !== exp_valid || data_out !== exp_data || sat_flag !== exp_sat) begin
                errors++;
                $display("[TB] FAIL gaps cycle %0d: got v%b %h s%b expected v%b %h s%b",
                         i, out_valid, data_out, sat_flag, exp_valid, exp_data, exp_sat);
            end
        end
    endtask

    task automatic test_reset_inflight();
        clock_cycle(1'b1, 'h3FF, 1, 1'b0);
        clock_cycle(1'b1, 'h000, 0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (data_out !== 10'h200 || out_valid !== 1'b0 || sat_flag !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: got v%b %h s%b expected v0 200 s0", out_valid, data_out, sat_flag);
        end
        model_clear();
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            clock_cycle(1'b0, 0, 0, 1'b0);
            checks++;
            if (out_valid !== 1'b0 || data_out !== 10'h200) begin
                errors++;
                $display("[TB] FAIL flushed cycle %0d: got v%b %h expected v0 200", i, out_valid, data_out);
            end
        end
        run_directed("restart", '{'h191}, '{0}, '{1'b1}, '{10'h204}, '{1'b0});
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            clock_cycle($urandom_range(0, 9) < 7, $urandom_range(0, 1023), $urandom_range(0, 3),
                        1'($urandom_range(0, 1)));
            checks++;
            if (out_valid !== exp_valid || data_out !== exp_data || sat_flag !== exp_sat) begin
                errors++;
                $display("[TB] FAIL random cycle %0d: got v%b %h s%b expected v%b %h s%b",
                         i, out_valid, data_out, sat_flag, exp_valid, exp_data, exp_sat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_midscale();
        test_gain();
        test_saturation();
        test_warmup();
        test_gaps();
        test_reset_inflight();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scaled_averager.md
SCALED_AVERAGER -- requirements
Module: scaled_averager

Interface
REQ-001 Parameter WIDTH, default 10, sample width of data_in and data_out.
REQ-002 Parameter ADC_OFFSET, default 10'h181, input zero code subtracted from every sample.
REQ-003 Parameter DAC_OFFSET, default 10'h200, output mid-scale code added to every result.
REQ-004 Parameter LOG2_DEPTH, default 2, moving-average depth DEPTH = 2**LOG2_DEPTH, legal range 1..4.
REQ-005 Port sysclk, input, 1 bit, single system clock; all state changes on its rising edge.
REQ-006 Port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-007 Port sample_valid, input, 1 bit, data_in holds a new sample this cycle.
REQ-008 Port data_in, input, WIDTH bits, offset-binary ADC sample.
REQ-009 Port gain_sel, input, 2 bits, gain = 2**gain_sel (x1, x2, x4, x8), sampled with data_in.
REQ-010 Port avg_en, input, 1 bit, 1 selects the moving average, 0 selects bypass; sampled with data_in.
REQ-011 Port data_out, output, WIDTH bits, registered offset-binary DAC code.
REQ-012 Port out_valid, output, 1 bit, one-cycle pulse when data_out updates.
REQ-013 Port sat_flag, output, 1 bit, qualified by out_valid; 1 when the current output was clamped.

Function
REQ-014 The block shall be a three-stage pipeline with a valid bit per stage, advancing every cycle; no backpressure.
REQ-015 Latency shall be exactly 3 cycles: sample_valid at edge N gives out_valid at edge N+3; back-to-back samples every cycle shall be accepted.
REQ-016 Cycles without sample_valid shall not change data_out, sat_flag, the buffer or the running sum.
REQ-017 Stage 1 shall compute x = data_in - ADC_OFFSET as a signed WIDTH+1-bit value, e.g. 0x000 -> -385, 0x3FF -> +638.
REQ-018 Stage 2 shall keep a circular buffer of the last DEPTH values of x and a signed running sum of WIDTH+1+LOG2_DEPTH bits.
REQ-019 On each valid sample, stage 2 shall apply sum <= sum + x - oldest, overwrite the oldest entry, and advance the write index modulo DEPTH, wrapping from DEPTH-1 to 0.
REQ-020 The buffer and sum shall update regardless of avg_en, so switching avg_en causes no transient beyond the normal window.
REQ-021 With avg_en=1, the stage 2 result shall be sum >>> LOG2_DEPTH, an arithmetic floor; with avg_en=0 it shall be x.
REQ-022 During warm-up after reset, empty entries shall count as 0, so the average ramps up; there is no fill counter.
REQ-023 Stage 3 shall compute y = result << gain_sel in at least WIDTH+4 signed bits, with no intermediate overflow.
REQ-024 Stage 3 shall clamp y to [-2**(WIDTH-1), 2**(WIDTH-1)-1] and set sat_flag=1 if clamped, else 0.
REQ-025 data_out shall equal (clamped y + DAC_OFFSET) modulo 2**WIDTH, so -512 -> 0x000 and +511 -> 0x3FF for WIDTH=10.

Reset
REQ-026 While rst_n=0, data_out shall be DAC_OFFSET, out_valid 0, sat_flag 0, all stage valid bits 0, buffer entries 0, sum 0, write index 0.
REQ-027 Reset asserted mid-operation shall discard in-flight samples; no out_valid shall appear for samples accepted before reset.
REQ-028 The first sample_valid after rst_n deasserts shall be processed normally, with the same 3-cycle latency.

Structure
REQ-029 A shared package proc_pkg shall hold the default ADC_OFFSET, DAC_OFFSET, WIDTH and LOG2_DEPTH constants and the saturate-to-WIDTH function.
REQ-030 The circular buffer and running sum shall be one sub-module, avg_buffer, with parameters WIDTH+1 and LOG2_DEPTH; all other logic stays in scaled_averager.

Verification (defaults)
REQ-031 Mid-scale: data_in=0x181, gain_sel=0, avg_en=0 -> data_out=0x200, sat_flag=0, out_valid exactly 3 cycles after sample_valid.
REQ-032 Gain: data_in=0x191 (x=16), gain_sel=2, avg_en=0 -> data_out=0x240; with gain_sel=3 -> 0x280.
REQ-033 Saturation: data_in=0x3FF, gain_sel=0 -> 0x3FF with sat_flag=1; data_in=0x000, gain_sel=1 (-770) -> 0x000 with sat_flag=1.
REQ-034 Averaging warm-up: after reset, four samples of data_in=0x191, avg_en=1, gain_sel=0 -> 0x204, 0x208, 0x20C, 0x210; a fifth sample of 0x181 -> 0x20C, exercising index wrap.
REQ-035 Gaps and reset: samples with 2-cycle gaps shall hold data_out between pulses; rst_n pulsed with 2 samples in flight -> no out_valid, data_out=0x200, and the next average restarts from a zero buffer.
